// File: rtl/eight_ten_pkg.sv
// Shared constants and helpers for the 8b/10b lane encoder.
package eight_ten_pkg;
  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  function automatic logic is_legal_k(input logic [7:0] b);
    return (b inside {K28_0, K28_1, K28_2, K28_3, K28_4, K28_5, K28_6, K28_7,
                      K23_7, K27_7, K29_7, K30_7});
  endfunction
endpackage

// File: rtl/eight_ten_lane_encoder_symbol.sv
// One-lane combinational 8b/10b symbol encoder (5b/6b + 3b/4b with A7 handling).
module eight_ten_symbol
  import eight_ten_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       rd_i,
  output logic [9:0] code_o,
  output logic       rd_o,
  output logic       k_err_o
);
  logic [4:0] x;
  logic [2:0] y;
  logic       legal, six_unbal, four_unbal, rd_mid, a7;
  logic [5:0] six_n, six;
  logic [3:0] four_n, four;

  always_comb begin
    x       = data_i[4:0];
    y       = data_i[7:5];
    legal   = k_i && is_legal_k(data_i);
    k_err_o = k_i && !legal;
    // Tables hold the RD- form; the RD+ form is the bitwise complement.
    case (x)
      5'd0:  six_n = 6'b100111;
      5'd1:  six_n = 6'b011101;
      5'd2:  six_n = 6'b101101;
      5'd3:  six_n = 6'b110001;
      5'd4:  six_n = 6'b110101;
      5'd5:  six_n = 6'b101001;
      5'd6:  six_n = 6'b011001;
      5'd7:  six_n = 6'b111000;
      5'd8:  six_n = 6'b111001;
      5'd9:  six_n = 6'b100101;
      5'd10: six_n = 6'b010101;
      5'd11: six_n = 6'b110100;
      5'd12: six_n = 6'b001101;
      5'd13: six_n = 6'b101100;
      5'd14: six_n = 6'b011100;
      5'd15: six_n = 6'b010111;
      5'd16: six_n = 6'b011011;
      5'd17: six_n = 6'b100011;
      5'd18: six_n = 6'b010011;
      5'd19: six_n = 6'b110010;
      5'd20: six_n = 6'b001011;
      5'd21: six_n = 6'b101010;
      5'd22: six_n = 6'b011010;
      5'd23: six_n = 6'b111010;
      5'd24: six_n = 6'b110011;
      5'd25: six_n = 6'b100110;
      5'd26: six_n = 6'b010110;
      5'd27: six_n = 6'b110110;
      5'd28: six_n = 6'b001110;
      5'd29: six_n = 6'b101110;
      5'd30: six_n = 6'b011110;
      default: six_n = 6'b101011;
    endcase
    if (legal && x == 5'd28) six_n = 6'b001111;
    // Balanced codes have three ones (odd parity); unbalanced ones have two or four.
    six_unbal = ~^six_n;
    six       = (rd_i && (six_unbal || six_n == 6'b111000)) ? ~six_n : six_n;
    rd_mid    = rd_i ^ six_unbal;

    a7 = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
         ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    if (legal) begin
      case (y)
        3'd0: four_n = 4'b1011;
        3'd1: four_n = 4'b0110;
        3'd2: four_n = 4'b1010;
        3'd3: four_n = 4'b1100;
        3'd4: four_n = 4'b1101;
        3'd5: four_n = 4'b0101;
        3'd6: four_n = 4'b1001;
        default: four_n = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0: four_n = 4'b1011;
        3'd1: four_n = 4'b1001;
        3'd2: four_n = 4'b0101;
        3'd3: four_n = 4'b1100;
        3'd4: four_n = 4'b1101;
        3'd5: four_n = 4'b1010;
        3'd6: four_n = 4'b0110;
        default: four_n = a7 ? 4'b0111 : 4'b1110;
      endcase
    end
    four_unbal = ^four_n;
    // Control codes flip every 4b group at RD+ so commas keep their shape.
    four   = (rd_mid && (four_unbal || four_n == 4'b1100 || legal)) ? ~four_n : four_n;
    rd_o   = rd_mid ^ four_unbal;
    code_o = {six, four};
  end
endmodule

// File: rtl/eight_ten_lane_encoder.sv
// Registered multi-lane 8b/10b encoder with RD chaining across lanes and cycles.
module eight_ten_lane_encoder
  import eight_ten_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_VALID,
  input  logic [8*LANES-1:0]    i_WORD,
  input  logic [LANES-1:0]      i_KIN,
  input  logic                  i_RD_FORCE,
  input  logic                  i_RD_FORCE_VAL,
  output logic                  o_VALID,
  output logic [10*LANES-1:0]   o_ENCODED_WORD,
  output logic [LANES-1:0]      o_K_ERR,
  output logic                  o_RD
);
  logic [LANES:0]          rd_chain;
  logic [LANES-1:0][9:0]   enc_d, enc_q;
  logic [LANES-1:0]        kerr_d, kerr_q;
  logic                    vld_q, rd_d, rd_q;

  assign rd_chain[0] = i_RD_FORCE ? i_RD_FORCE_VAL : rd_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    eight_ten_symbol u_sym (
      .data_i  (i_WORD[8*gi +: 8]),
      .k_i     (i_KIN[gi]),
      .rd_i    (rd_chain[gi]),
      .code_o  (enc_d[gi]),
      .rd_o    (rd_chain[gi+1]),
      .k_err_o (kerr_d[gi])
    );
  end

  // Idle cycles still honour a force: rd_chain[0] already carries it.
  always_comb begin
    rd_d = i_VALID ? rd_chain[LANES] : rd_chain[0];
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      vld_q  <= 1'b0;
      enc_q  <= '0;
      kerr_q <= '0;
      rd_q   <= RD_NEG;
    end else begin
      vld_q <= i_VALID;
      rd_q  <= rd_d;
      if (i_VALID) begin
        enc_q  <= enc_d;
        kerr_q <= kerr_d;
      end
    end
  end

  assign o_VALID        = vld_q;
  assign o_ENCODED_WORD = enc_q;
  assign o_K_ERR        = kerr_q;
  assign o_RD           = rd_q;
endmodule

// File: doc/eight_ten_lane_encoder.md
# eight_ten_lane_encoder

Registered, multi-lane 8b/10b encoder. Each accepted cycle it encodes LANES bytes, chaining running disparity (RD) from lane 0 to lane LANES-1 and across cycles. It adds valid qualification, RD override and invalid-control-code detection. It sits between the framing logic and the serializer of each transmit link.

## Interface

**Parameters**
- LANES, 2, bytes encoded per cycle; legal range 1..8.

**Ports**
- i_CLK  in  1  rising-edge clock.
- i_RST  in  1  synchronous, active-high reset.
- i_VALID  in  1  input word valid this cycle.
- i_WORD  in  8*LANES  bytes; lane n occupies [8n+7:8n], bit order HGFEDCBA.
- i_KIN  in  LANES  per-lane control flag; bit n qualifies lane n.
- i_RD_FORCE  in  1  override the starting RD for this cycle.
- i_RD_FORCE_VAL  in  1  forced RD value; 0 = RD−, 1 = RD+.
- o_VALID  out  1  o_ENCODED_WORD valid.
- o_ENCODED_WORD  out  10*LANES  lane n at [10n+9:10n], ordered {abcdei,fghj}, with a at bit 10n+9.
- o_K_ERR  out  LANES  lane n requested an illegal control code.
- o_RD  out  1  registered running disparity after the last accepted word.

## Operation

- **State:** the RD register r_RD. Reset value is 0 (RD−).
- **Starting RD** for lane 0: i_RD_FORCE_VAL when i_RD_FORCE=1, else r_RD.
- **Lane chain:** lane n is encoded with the RD out of lane n−1, using standard 5b/6b + 3b/4b tables.
  - The alternate D.x.7 (A7) encoding is applied when required.
  - RD out of lane LANES−1 is the new RD.
- **Legal controls:** K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
- **Illegal control** (i_KIN[n]=1 with any other byte):
  - Lane n is encoded as the data code for that byte.
  - o_K_ERR[n]=1.
  - The RD chain continues normally.
- **i_VALID=1:**
  - Register the outputs.
  - r_RD ← chain RD out.
  - o_VALID ← 1.
- **i_VALID=0:**
  - o_VALID ← 0.
  - o_ENCODED_WORD and o_K_ERR hold their previous values.
  - If i_RD_FORCE=1, r_RD ← i_RD_FORCE_VAL; otherwise r_RD holds.
- **Precedence:**
  - i_RST overrides all inputs in the same cycle.
  - i_RD_FORCE together with i_VALID: the forced value seeds lane 0, and the register takes the chain result.
- o_RD always equals r_RD.

## Timing

- Latency is 1 cycle: inputs sampled at edge k appear at the outputs after edge k.
- Throughput is LANES symbols per cycle, with no stall.
- Input to the registers is combinational through LANES chained lane encoders. This is the critical path and scales linearly with LANES.
- **Reset values** after an edge with i_RST=1:
  - o_VALID=0
  - o_ENCODED_WORD=0
  - o_K_ERR=0
  - r_RD=0, so o_RD=0.
- **Reset mid-stream:** the word presented in the reset cycle is discarded. The next valid word encodes from RD−.
- No backpressure. Upstream may present a word every cycle.

## Structure

- **Package `eight_ten_pkg`:**
  - RD encoding constants RD_NEG=0 and RD_POS=1.
  - The legal-K list as byte constants, including K28_5=8'hBC.
  - Function is_legal_k(byte).
- **Sub-module `eight_ten_symbol`:**
  - Combinational, one lane.
  - Inputs: byte, k flag, RD in.
  - Outputs: 10-bit code, RD out, k_err.
  - Instantiated LANES times in a generate loop, with RD out wired to the next lane's RD in.
- The top level holds r_RD, the output registers and the force mux.

## Test plan

- **Reset:** assert i_RST for 2 cycles with random inputs → o_VALID=0, o_ENCODED_WORD=0, o_K_ERR=0, o_RD=0.
- **Cross-cycle RD chaining:** LANES=1, RD−, send K28.5 (0xBC, K=1) → 0011111010 and o_RD=1. Next cycle send K28.5 → 1100000101 and o_RD=0.
- **Lane chaining:** LANES=2, RD−, send {0xBC,0xBC} with K=2'b11 → lane0=0011111010, lane1=1100000101, o_RD=0.
- **Data at both RDs:** LANES=1, RD−, send D0.0 (0x00) → 1001110100 and o_RD=0. Then force RD+ and send 0x00 → 0110001011 and o_RD=1.
- **Neutral code and hold:** send D21.5 (0xB5) → 1010101010 with o_RD unchanged. Then drop i_VALID → o_VALID=0, outputs hold, o_RD unchanged.
- **Illegal control:** i_KIN=1 with byte 0x00 at RD− → o_K_ERR=1, output 1001110100. Next legal word → o_K_ERR=0.
